gf_mult_seq: RTL

GF_MULT_SEQ -- requirements
Module: gf_mult_seq

---
 rtl/gf_pkg.sv | 20 ++
 rtl/gf_mult_seq_if.sv | 24 ++
 rtl/gf_digit_step.sv | 28 ++
 rtl/gf_mult_seq.sv | 110 +++++++++++
 4 files changed

// File: rtl/gf_pkg.sv
// Shared types and default constants for the sequential GF(2^m) multiplier.
package gf_pkg;

  typedef enum logic {
    GF_OP_MUL = 1'b0,
    GF_OP_MAC = 1'b1
  } gf_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } gf_state_e;

  localparam int         GF_M_DEF      = 8;
  localparam logic [7:0] PRIM_POLY_DEF = 8'h5F;
  localparam int         GF_M_MIN      = 2;
  localparam int         GF_M_MAX      = 16;

endpackage

// File: rtl/gf_mult_seq_if.sv
// Operand/result handshake bundle for gf_mult_seq.
interface gf_mult_seq_if #(
  parameter int GF_M = 8
);
  logic            in_valid;
  logic            in_ready;
  logic            in_op;
  logic [GF_M-1:0] in_a;
  logic [GF_M-1:0] in_b;
  logic [GF_M-1:0] in_d;
  logic            out_valid;
  logic            out_ready;
  logic [GF_M-1:0] out_c;

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_d, out_ready,
    output in_ready, out_valid, out_c
  );

  modport master (
    output in_valid, in_op, in_a, in_b, in_d, out_ready,
    input  in_ready, out_valid, out_c
  );
endinterface

// File: rtl/gf_digit_step.sv
// One digit-serial update: r_o = r_i * x^DIGIT ^ a_i * b_dig_i, all modulo P.
module gf_digit_step #(
  parameter int              GF_M      = 8,
  parameter logic [GF_M-1:0] PRIM_POLY = GF_M'(8'h5F),
  parameter int              DIGIT     = 1
) (
  input  logic [GF_M-1:0]  r_i,
  input  logic [GF_M-1:0]  a_i,
  input  logic [DIGIT-1:0] b_dig_i,
  output logic [GF_M-1:0]  r_o
);

  function automatic logic [GF_M-1:0] xtime(input logic [GF_M-1:0] v);
    xtime = {v[GF_M-2:0], 1'b0} ^ (v[GF_M-1] ? PRIM_POLY : '0);
  endfunction

  logic [GF_M-1:0] acc;

  // Horner over the digit bits, MSB first, folds the shift of R into the same chain.
  always_comb begin
    acc = r_i;
    for (int i = DIGIT - 1; i >= 0; i--) begin
      acc = xtime(acc) ^ (b_dig_i[i] ? a_i : '0);
    end
    r_o = acc;
  end

endmodule

// File: rtl/gf_mult_seq.sv
// Sequential GF(2^m) multiply / multiply-accumulate, DIGIT multiplier bits per cycle.
module gf_mult_seq
  import gf_pkg::*;
#(
  parameter int              GF_M      = GF_M_DEF,
  parameter logic [GF_M-1:0] PRIM_POLY = GF_M'(PRIM_POLY_DEF),
  parameter int              DIGIT     = 1
) (
  input  logic         clk,
  input  logic         rst,
  gf_mult_seq_if.slave bus
);

  if (GF_M < GF_M_MIN || GF_M > GF_M_MAX) begin : g_bad_m
    $error("gf_mult_seq: GF_M must lie in 2..16");
  end
  if (DIGIT < 1 || (GF_M % DIGIT) != 0) begin : g_bad_digit
    $error("gf_mult_seq: DIGIT must divide GF_M");
  end

  localparam int               N     = GF_M / DIGIT;
  localparam int               CNT_W = $clog2(N + 1);
  localparam logic [CNT_W-1:0] N_CNT = CNT_W'(N);

  gf_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [GF_M-1:0]  r_q, r_d;
  logic [GF_M-1:0]  c_q, c_d;
  logic [GF_M-1:0]  a_q, a_d;
  logic [GF_M-1:0]  b_q, b_d;
  logic [GF_M-1:0]  d_q, d_d;
  gf_op_e           op_q, op_d;
  logic [GF_M-1:0]  r_step;

  gf_digit_step #(
    .GF_M      (GF_M),
    .PRIM_POLY (PRIM_POLY),
    .DIGIT     (DIGIT)
  ) u_step (
    .r_i     (r_q),
    .a_i     (a_q),
    .b_dig_i (b_q[GF_M-1 -: DIGIT]),
    .r_o     (r_step)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    c_d     = c_q;
    a_d     = a_q;
    b_d     = b_q;
    d_d     = d_q;
    op_d    = op_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.in_a;
          b_d     = bus.in_b;
          d_d     = bus.in_d;
          op_d    = gf_op_e'(bus.in_op);
          r_d     = '0;
          cnt_d   = N_CNT;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        r_d   = r_step;
        b_d   = b_q << DIGIT;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          c_d     = r_step ^ ((op_q == GF_OP_MAC) ? d_q : '0);
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and result state; cleared asynchronously so no in-flight result survives reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      c_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      c_q     <= c_d;
    end
  end

  // Operand holding registers; only meaningful after an accept, so left unreset.
  always_ff @(posedge clk) begin
    a_q  <= a_d;
    b_q  <= b_d;
    d_q  <= d_d;
    op_q <= op_d;
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.out_c     = c_q;

endmodule
